// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_pkg
// Purpose  : Shared types and constants for the vector co-processor:
//            opcode/funct3 enums, load width and mop encodings, FSM states,
//            machine widths and small decode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vec_pkg;

  localparam int XLEN      = 32;
  localparam int VLEN      = 128;
  localparam int SEW       = 32;
  localparam int NUM_VREGS = 32;

  typedef enum logic [6:0] {
    V_ARITH = 7'h57,
    V_LOAD  = 7'h07
  } opcode_e;

  typedef enum logic [2:0] {
    CONF = 3'b111
  } funct3_e;

  // Load width field encodings
  localparam logic [2:0] WIDTH_E8  = 3'b000;
  localparam logic [2:0] WIDTH_E16 = 3'b101;
  localparam logic [2:0] WIDTH_E32 = 3'b110;

  // Internal element-width code used by the load datapath
  localparam logic [1:0] EEW_8  = 2'd0;
  localparam logic [1:0] EEW_16 = 2'd1;
  localparam logic [1:0] EEW_32 = 2'd2;

  // Load addressing modes
  localparam logic [1:0] MOP_UNIT    = 2'b00;
  localparam logic [1:0] MOP_STRIDED = 2'b10;

  // vtype bits that may be non-zero in a legal setting: vma, vta, vsew
  localparam logic [XLEN-1:0] VTYPE_FREE_BITS = 32'h0000_00F8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Config variants: vsetvli (bit31=0), vsetivli (11), vsetvl (1000000)
  function automatic logic cfg_variant_ok(input logic [6:0] f7);
    return (!f7[6]) || (f7[6:5] == 2'b11) || (f7 == 7'b1000000);
  endfunction

  // VLMAX for LMUL=1 and a legal vsew
  function automatic logic [XLEN-1:0] vlmax_for_sew(input logic [2:0] vsew);
    logic [XLEN-1:0] r;
    case (vsew)
      3'b000:  r = XLEN'(VLEN / 8);
      3'b001:  r = XLEN'(VLEN / 16);
      default: r = XLEN'(VLEN / 32);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_csr_regfile.sv
`default_nettype none
// ============================================================================
// Module   : vec_csr_regfile
// Purpose  : Holds vl and the vill flag and computes the new vl for the
//            vsetvli / vsetivli / vsetvl configuration instructions.
// Ports    : clk, reset (async, active-low)
//            cfg_en    - commit a configuration instruction this cycle
//            cfg_bits  - instruction[31:15] (variant, zimm, rs1/uimm)
//            rd_is_x0  - destination register field is x0
//            rs1_data  - AVL for vsetvli/vsetvl
//            rs2_data  - vtype for vsetvl
//            vl, vill  - current configuration state
// Revision : 1.0 - initial release
// ============================================================================
module vec_csr_regfile
  import vec_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_en,
  input  logic [16:0]     cfg_bits,
  input  logic            rd_is_x0,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] vl,
  output logic            vill
);

  logic [XLEN-1:0] vl_q, vl_d;
  logic            vill_q, vill_d;
  logic [XLEN-1:0] vtype_new, avl, vlmax;
  logic            uses_rs1, rs1_is_x0, vtype_ok;

  always_comb begin
    rs1_is_x0 = (cfg_bits[4:0] == 5'd0);
    if (cfg_bits[16:15] == 2'b11) begin
      // vsetivli: 10-bit zimm, 5-bit immediate AVL
      uses_rs1  = 1'b0;
      vtype_new = {{(XLEN-10){1'b0}}, cfg_bits[14:5]};
      avl       = {{(XLEN-5){1'b0}}, cfg_bits[4:0]};
    end else if (!cfg_bits[16]) begin
      // vsetvli: 11-bit zimm
      uses_rs1  = 1'b1;
      vtype_new = {{(XLEN-11){1'b0}}, cfg_bits[15:5]};
      avl       = rs1_data;
    end else begin
      // vsetvl: vtype from register
      uses_rs1  = 1'b1;
      vtype_new = rs2_data;
      avl       = rs1_data;
    end

    // Only vma/vta/vsew may be set; LMUL fixed at 1; SEW up to 32
    vtype_ok = ((vtype_new & ~VTYPE_FREE_BITS) == '0) && (vtype_new[5:3] <= 3'd2);
    vlmax    = vlmax_for_sew(vtype_new[5:3]);

    vl_d   = vl_q;
    vill_d = vill_q;
    if (cfg_en) begin
      if (!vtype_ok) begin
        vill_d = 1'b1;
        vl_d   = '0;
      end else begin
        vill_d = 1'b0;
        if (uses_rs1 && rs1_is_x0) begin
          // rs1=x0: rd!=x0 requests VLMAX, rd=x0 keeps the current vl
          vl_d = rd_is_x0 ? vl_q : vlmax;
        end else begin
          vl_d = (avl < vlmax) ? avl : vlmax;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vl_q   <= '0;
      vill_q <= 1'b1;
    end else begin
      vl_q   <= vl_d;
      vill_q <= vill_d;
    end
  end

  assign vl   = vl_q;
  assign vill = vill_q;

endmodule
`default_nettype wire

// File: rtl/vector_coprocessor.sv
`default_nettype none
// ============================================================================
// Module   : vector_coprocessor
// Purpose  : Minimal RISC-V V co-processor. Executes vector configuration
//            instructions and unit-stride (optionally strided) vector loads
//            into a 32 x VLEN register file, one element per cycle.
// Ports    : clk, reset (async, active-low)
//            instruction, rs1_data, rs2_data - from the scalar core
//            is_vec        - instruction is a supported vector instruction
//            is_loaded     - pulse when the last load element is written
//            ld_inst       - load is accessing memory
//            mem2lsu_data  - combinational read data at lsu2mem_addr
//            lsu2mem_addr  - byte address of current element
//            csr_out       - vl from the last configuration instruction
//            vec_pro_ack   - pulse: previous instruction completed
//            vec_pro_ready - idle, instruction input sampled
// Config   : VEC_STRIDED_LOAD_EN - enables mop=10 strided loads
// Revision : 1.0 - initial release
// ============================================================================
module vector_coprocessor
  import vec_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            is_vec,
  output logic            is_loaded,
  output logic            ld_inst,
  input  logic [SEW-1:0]  mem2lsu_data,
  output logic [XLEN-1:0] lsu2mem_addr,
  output logic [XLEN-1:0] csr_out,
  output logic            vec_pro_ack,
  output logic            vec_pro_ready
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] stride_q, stride_d;
  logic [1:0]      eew_q, eew_d;
  logic [4:0]      vd_q, vd_d;
  logic [4:0]      idx_q, idx_d;
  logic [4:0]      n_q, n_d;
  logic            vm_q, vm_d;
  logic            zero_ld_q, zero_ld_d;

  logic [VLEN-1:0] vreg [NUM_VREGS];

  // Decode
  logic            cfg_ok, ld_ok, ld_width_ok, ld_mop_ok, accept;
  logic [1:0]      ld_eew, ld_mop;
  logic [XLEN-1:0] ld_stride, unit_stride, elem_max;
  logic [4:0]      ld_n;
  logic [XLEN-1:0] vl;
  logic            vill;

  // Datapath
  logic            last_elem, elem_we;
  logic [6:0]      bit_off;
  logic [VLEN-1:0] elem_mask, wr_mask, wr_data;

  always_comb begin
    ld_eew      = EEW_8;
    ld_width_ok = 1'b0;
    elem_max    = XLEN'(VLEN / 8);
    case (instruction[14:12])
      WIDTH_E8:  begin ld_eew = EEW_8;  ld_width_ok = 1'b1; elem_max = XLEN'(VLEN / 8);  end
      WIDTH_E16: begin ld_eew = EEW_16; ld_width_ok = 1'b1; elem_max = XLEN'(VLEN / 16); end
      WIDTH_E32: begin ld_eew = EEW_32; ld_width_ok = 1'b1; elem_max = XLEN'(VLEN / 32); end
      default:   ;
    endcase

    ld_mop = instruction[27:26];
`ifdef VEC_STRIDED_LOAD_EN
    ld_mop_ok = (ld_mop == MOP_UNIT) || (ld_mop == MOP_STRIDED);
`else
    ld_mop_ok = (ld_mop == MOP_UNIT);
`endif

    // nf must be 0 and mew must be 0
    ld_ok  = (instruction[6:0] == V_LOAD) && ld_width_ok && ld_mop_ok &&
             (instruction[31:29] == 3'b000) && !instruction[28];
    cfg_ok = (instruction[6:0] == V_ARITH) && (instruction[14:12] == CONF) &&
             cfg_variant_ok(instruction[31:25]);
    is_vec = cfg_ok || ld_ok;
    accept = (state_q == S_IDLE) && is_vec;

    unit_stride = {{(XLEN-1){1'b0}}, 1'b1} << ld_eew;
    ld_stride   = (ld_mop == MOP_STRIDED) ? rs2_data : unit_stride;
    ld_n        = vill ? 5'd0 : ((vl < elem_max) ? vl[4:0] : elem_max[4:0]);
  end

  vec_csr_regfile u_csr (
    .clk      (clk),
    .reset    (reset),
    .cfg_en   (accept && cfg_ok),
    .cfg_bits (instruction[31:15]),
    .rd_is_x0 (instruction[11:7] == 5'd0),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .vl       (vl),
    .vill     (vill)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cfg_ok || (ld_n == 5'd0)) state_d = S_DONE;
          else                          state_d = S_LOAD;
        end
      end
      S_LOAD:  if (last_elem) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    vec_pro_ready = (state_q == S_IDLE);
    ld_inst       = (state_q == S_LOAD);
    vec_pro_ack   = (state_q == S_DONE);
    last_elem     = (idx_q == (n_q - 5'd1));
    // A zero-length load still reports completion, during its DONE cycle
    is_loaded     = ((state_q == S_LOAD) && last_elem) || zero_ld_q;
    elem_we       = (state_q == S_LOAD) && (vm_q || vreg[0][{2'b00, idx_q}]);
  end

  // Load sequencing state
  always_comb begin
    addr_d    = addr_q;
    stride_d  = stride_q;
    eew_d     = eew_q;
    vd_d      = vd_q;
    vm_d      = vm_q;
    idx_d     = idx_q;
    n_d       = n_q;
    zero_ld_d = 1'b0;
    if (accept && ld_ok) begin
      addr_d    = rs1_data;
      stride_d  = ld_stride;
      eew_d     = ld_eew;
      vd_d      = instruction[11:7];
      vm_d      = instruction[25];
      idx_d     = 5'd0;
      n_d       = ld_n;
      zero_ld_d = (ld_n == 5'd0);
    end else if (state_q == S_LOAD) begin
      addr_d = addr_q + stride_q;
      idx_d  = idx_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      stride_q  <= '0;
      eew_q     <= EEW_8;
      vd_q      <= '0;
      vm_q      <= 1'b0;
      idx_q     <= '0;
      n_q       <= '0;
      zero_ld_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      eew_q     <= eew_d;
      vd_q      <= vd_d;
      vm_q      <= vm_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      zero_ld_q <= zero_ld_d;
    end
  end

  // Element write: replicate the low EEW bits and merge under a lane mask
  always_comb begin
    case (eew_q)
      EEW_8: begin
        bit_off   = {idx_q[3:0], 3'b000};
        elem_mask = {{(VLEN-8){1'b0}}, 8'hFF};
        wr_data   = {(VLEN/8){mem2lsu_data[7:0]}};
      end
      EEW_16: begin
        bit_off   = {idx_q[2:0], 4'b0000};
        elem_mask = {{(VLEN-16){1'b0}}, 16'hFFFF};
        wr_data   = {(VLEN/16){mem2lsu_data[15:0]}};
      end
      default: begin
        bit_off   = {idx_q[1:0], 5'b00000};
        elem_mask = {{(VLEN-32){1'b0}}, 32'hFFFF_FFFF};
        wr_data   = {(VLEN/SEW){mem2lsu_data}};
      end
    endcase
    wr_mask = elem_mask << bit_off;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_VREGS; r++) vreg[r] <= '0;
    end else if (elem_we) begin
      vreg[vd_q] <= (vreg[vd_q] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign lsu2mem_addr = addr_q;
  assign csr_out      = vl;

endmodule
`default_nettype wire

// File: tb/tb_vector_coprocessor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_coprocessor
// Purpose  : Directed self-checking bench for vector_coprocessor with
//            hand-computed expected values. Memory returns 0xCAFE0000|addr.
// Config   : VEC_STRIDED_LOAD_EN - selects the strided-load expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_coprocessor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic        is_vec, is_loaded, ld_inst, vec_pro_ack, vec_pro_ready;
  logic [31:0] mem2lsu_data, lsu2mem_addr, csr_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instruction observations
  logic [31:0] addr_log [16];
  int          n_addr;
  int          ack_cyc;
  int          loaded_cyc;
  int          ready_lo;
  logic        vec_seen;
  logic        acked;

  always #5 clk = ~clk;

  assign mem2lsu_data = 32'hCAFE_0000 | {16'h0, lsu2mem_addr[15:0]};

  vector_coprocessor dut (
    .clk           (clk),
    .reset         (reset),
    .instruction   (instruction),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .is_vec        (is_vec),
    .is_loaded     (is_loaded),
    .ld_inst       (ld_inst),
    .mem2lsu_data  (mem2lsu_data),
    .lsu2mem_addr  (lsu2mem_addr),
    .csr_out       (csr_out),
    .vec_pro_ack   (vec_pro_ack),
    .vec_pro_ready (vec_pro_ready)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                               input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_load(input logic [1:0] mop, input logic vm,
                                           input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [2:0] width, input logic [4:0] vd);
    return {3'b000, 1'b0, mop, vm, rs2, rs1, width, vd, 7'h07};
  endfunction

  // Present one instruction, let it be accepted, then watch until ack (bounded)
  task automatic run(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2);
    n_addr = 0; ack_cyc = 0; loaded_cyc = 0; ready_lo = 0; acked = 1'b0;
    @(negedge clk);
    instruction = inst; rs1_data = r1; rs2_data = r2;
    #1 vec_seen = is_vec;
    @(negedge clk);
    instruction = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      if (!vec_pro_ready) ready_lo++;
      if (ld_inst && n_addr < 16) begin
        addr_log[n_addr] = lsu2mem_addr;
        n_addr++;
      end
      if (is_loaded) loaded_cyc = c;
      if (vec_pro_ack) begin
        ack_cyc = c;
        acked   = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready", vec_pro_ready, 1);
    check_eq("rst_ack", vec_pro_ack, 0);
    check_eq("rst_ld_inst", ld_inst, 0);
    check_eq("rst_is_loaded", is_loaded, 0);
    check_eq("rst_csr_out", csr_out, 0);
    check_eq("rst_addr", lsu2mem_addr, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_vreg2", dut.vreg[2], 0);

    // vsetvli x1,x2,e32,m1 with AVL=16 -> vl=4
    run(enc_vsetvli(5'd1, 5'd2, 11'h010), 32'd16, 32'd0);
    check_eq("vsetvli_is_vec", vec_seen, 1);
    check_eq("vsetvli_csr", csr_out, 4);
    check_eq("vsetvli_ack_cyc", ack_cyc, 1);
    check_eq("vsetvli_ready_lo", ready_lo, 1);
    @(negedge clk);
    check_eq("vsetvli_ready_back", vec_pro_ready, 1);
    check_eq("vsetvli_ack_pulse", vec_pro_ack, 0);

    // vsetivli e8 AVL=10 -> vl=10
    run(enc_vsetivli(5'd1, 5'd10, 10'h000), 32'd0, 32'd0);
    check_eq("vsetivli_csr", csr_out, 10);

    // vsetvli rs1=x0, rd=x5, e16 -> VLMAX=8
    run(enc_vsetvli(5'd5, 5'd0, 11'h008), 32'h77, 32'd0);
    check_eq("vsetvli_vlmax_csr", csr_out, 8);

    // vsetvli rs1=x0, rd=x0 -> vl kept
    run(enc_vsetvli(5'd0, 5'd0, 11'h010), 32'h77, 32'd0);
    check_eq("vsetvli_keep_csr", csr_out, 8);

    // vsetvl with vsew=011 -> vill, vl=0
    run(enc_vsetvl(5'd1, 5'd2, 5'd3), 32'd16, 32'h18);
    check_eq("vsetvl_vill_csr", csr_out, 0);
    check_eq("vsetvl_ack_cyc", ack_cyc, 1);

    // Load under vill: no memory access, is_loaded and ack in the next cycle
    run(enc_load(2'b00, 1'b1, 5'd0, 5'd1, 3'b110, 5'd3), 32'h200, 32'd0);
    check_eq("vill_ld_naddr", n_addr, 0);
    check_eq("vill_ld_loaded", loaded_cyc, 1);
    check_eq("vill_ld_ack", ack_cyc, 1);
    check_eq("vill_ld_vreg3", dut.vreg[3], 0);

    // vle32 v2,(x1) base 0x40, vl=4
    run(enc_vsetvli(5'd1, 5'd2, 11'h010), 32'd16, 32'd0);
    check_eq("vl4_csr", csr_out, 4);
    run(enc_load(2'b00, 1'b1, 5'd0, 5'd1, 3'b110, 5'd2), 32'h40, 32'd0);
    check_eq("vle32_naddr", n_addr, 4);
    check_eq("vle32_addr0", addr_log[0], 32'h40);
    check_eq("vle32_addr1", addr_log[1], 32'h44);
    check_eq("vle32_addr2", addr_log[2], 32'h48);
    check_eq("vle32_addr3", addr_log[3], 32'h4C);
    check_eq("vle32_loaded_cyc", loaded_cyc, 4);
    check_eq("vle32_ack_cyc", ack_cyc, 5);
    check_eq("vle32_vreg2", dut.vreg[2], 128'hCAFE004C_CAFE0048_CAFE0044_CAFE0040);

    // v0 mask = ...0101 from word 0xCAFE0005
    run(enc_load(2'b00, 1'b1, 5'd0, 5'd1, 3'b110, 5'd0), 32'h05, 32'd0);
    check_eq("vle32_v0", dut.vreg[0], 128'hCAFE0011_CAFE000D_CAFE0009_CAFE0005);

    // Masked vle32 v2 base 0x100: only elements 0 and 2 overwritten
    run(enc_load(2'b00, 1'b0, 5'd0, 5'd1, 3'b110, 5'd2), 32'h100, 32'd0);
    check_eq("masked_ack_cyc", ack_cyc, 5);
    check_eq("masked_vreg2", dut.vreg[2], 128'hCAFE004C_CAFE0108_CAFE0044_CAFE0100);

    // Strided vlse8 v4 base 0x80 stride 3, vl=4
    run(enc_vsetvli(5'd1, 5'd2, 11'h000), 32'd4, 32'd0);
    check_eq("e8_vl4_csr", csr_out, 4);
    run(enc_load(2'b10, 1'b1, 5'd3, 5'd1, 3'b000, 5'd4), 32'h80, 32'd3);
`ifdef VEC_STRIDED_LOAD_EN
    check_eq("vlse8_is_vec", vec_seen, 1);
    check_eq("vlse8_addr0", addr_log[0], 32'h80);
    check_eq("vlse8_addr1", addr_log[1], 32'h83);
    check_eq("vlse8_addr2", addr_log[2], 32'h86);
    check_eq("vlse8_addr3", addr_log[3], 32'h89);
    check_eq("vlse8_ack_cyc", ack_cyc, 5);
    check_eq("vlse8_vreg4", dut.vreg[4], 128'h89868380);
`else
    check_eq("vlse8_is_vec", vec_seen, 0);
    check_eq("vlse8_no_ack", acked, 0);
    check_eq("vlse8_no_access", n_addr, 0);
    check_eq("vlse8_vreg4", dut.vreg[4], 0);
`endif

    // Non-vector / unsupported encodings
    @(negedge clk);
    instruction = 32'h0000_2007;   // flw-style width 010
    #1 check_eq("flw_is_vec", is_vec, 0);
    instruction = 32'h8200_7057;   // config with bits31:25 = 1000001
    #1 check_eq("badcfg_is_vec", is_vec, 0);
    instruction = 32'h1000_6007;   // vle32 with mew=1
    #1 check_eq("mew_is_vec", is_vec, 0);
    instruction = 32'h0;

    // Reset in the middle of a vle32 into v5
    @(negedge clk);
    instruction = enc_load(2'b00, 1'b1, 5'd0, 5'd1, 3'b110, 5'd5);
    rs1_data    = 32'h300;
    @(negedge clk);
    instruction = 32'h0;
    @(negedge clk);
    check_eq("midrst_ld_inst", ld_inst, 1);
    check_eq("midrst_elem0", dut.vreg[5][31:0], 32'hCAFE0300);
    reset = 1'b0;
    #1;
    check_eq("midrst_ld_inst_off", ld_inst, 0);
    check_eq("midrst_vreg5", dut.vreg[5], 0);
    check_eq("midrst_vreg2", dut.vreg[2], 0);
    check_eq("midrst_csr", csr_out, 0);
    check_eq("midrst_ready", vec_pro_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
